// File: rtl/mux_demux_pipe_n.sv
// Registered N-channel mux->demux: routes the selected input channel through a 2-entry tagged FIFO
// to the same-index output channel. Define MUX_DEMUX_RR_EN to replace sel with a round-robin arbiter.
module mux_demux_pipe_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     inp,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  input  logic [SELW-1:0]                    sel,
  output logic [CHANNELS-1:0][WIDTH-1:0]     outp,
  output logic [CHANNELS-1:0]                out_valid,
  input  logic [CHANNELS-1:0]                out_ready,
  output logic [1:0]                         count
);

  logic [1:0][WIDTH-1:0] buf_data;
  logic [1:0][SELW-1:0]  buf_tag;
  logic                  wptr, rptr;
  logic [SELW-1:0]       src;
  logic                  src_ok;
  logic                  full, push, pop;
  logic [SELW-1:0]       head_tag;

  assign full = (count == 2'd2);

`ifdef MUX_DEMUX_RR_EN
  logic [SELW-1:0] last_grant;
  int              idx;

  // Search starts just past the last granted channel so every requester gets a turn.
  always_comb begin
    src    = '0;
    src_ok = 1'b0;
    idx    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(last_grant) + 1 + k) % CHANNELS;
      if (!src_ok && in_valid[idx]) begin
        src    = SELW'(idx);
        src_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= SELW'(CHANNELS - 1);
    else if (push) last_grant <= src;
  end
`else
  // Out-of-range sel (non-power-of-two CHANNELS) selects nothing.
  always_comb begin
    src    = sel;
    src_ok = ({1'b0, sel} < (SELW+1)'(CHANNELS));
  end
`endif

  // Ready depends only on registered occupancy and the source choice, never on out_ready.
  always_comb begin
    in_ready = '0;
    if (src_ok && !full) in_ready[src] = 1'b1;
  end

  assign push = src_ok && !full && in_valid[src];

  assign head_tag = buf_tag[rptr];

  always_comb begin
    out_valid = '0;
    outp      = '0;
    if (count != 2'd0) begin
      out_valid[head_tag] = 1'b1;
      outp[head_tag]      = buf_data[rptr];
    end
  end

  assign pop = (count != 2'd0) && out_ready[head_tag];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wptr] <= inp[src];
      buf_tag[wptr]  <= src;
    end
  end

endmodule

// File: tb/tb_mux_demux_pipe_n.sv
// Self-checking bench for mux_demux_pipe_n (default sel-driven build): directed scenarios plus a
// queue scoreboard that predicts every output from observed handshakes.
module tb_mux_demux_pipe_n;
  localparam int W  = 16;
  localparam int C  = 4;
  localparam int SW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [C-1:0][W-1:0] inp;
  logic [C-1:0]        in_valid;
  logic [C-1:0]        in_ready;
  logic [SW-1:0]       sel;
  logic [C-1:0][W-1:0] outp;
  logic [C-1:0]        out_valid;
  logic [C-1:0]        out_ready;
  logic [1:0]          count;

  int vectors    = 0;
  int miscompares = 0;
  int pops       = 0;

  mux_demux_pipe_n #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .outp(outp), .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: entries pushed on observed accept, popped on observed delivery.
  logic [SW+W-1:0]     q[$];
  logic [C-1:0]        eov, eir;
  logic [C-1:0][W-1:0] eop;
  logic [SW-1:0]       htag;
  int                  n;
  logic                do_pop, do_push;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      n   = q.size();
      eov = '0;
      eop = '0;
      htag = '0;
      if (n > 0) begin
        htag = q[0][SW+W-1:W];
        eov[htag] = 1'b1;
        eop[htag] = q[0][W-1:0];
      end
      eir = (n != 2) ? (C'(1) << sel) : '0;
      vectors++;
      if (out_valid !== eov || outp !== eop) begin
        miscompares++;
        $display("FAIL sb_out: out_valid=%b outp=%h want out_valid=%b outp=%h", out_valid, outp, eov, eop);
      end
      vectors++;
      if (count !== 2'(n)) begin
        miscompares++;
        $display("FAIL sb_count: got %0d want %0d", count, n);
      end
      vectors++;
      if (in_ready !== eir) begin
        miscompares++;
        $display("FAIL sb_in_ready: got %b want %b", in_ready, eir);
      end
      do_pop  = (n > 0) && out_ready[htag];
      do_push = (n != 2) && in_valid[sel];
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (do_push) q.push_back({sel, inp[sel]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inp = '0; in_valid = '0; out_ready = '0; sel = 2'd1;
    #1;
    vectors++;
    if (count !== 2'd0 || out_valid !== '0 || outp !== '0) begin
      miscompares++;
      $display("FAIL reset_init: count=%0d out_valid=%b outp=%h want 0", count, out_valid, outp);
    end
    cyc(); cyc();
    rst = 1'b0;
    inp[1] = 16'h00AA; in_valid = 4'b0010;
    cyc(); cyc();
    in_valid = '0;
    vectors++;
    if (count !== 2'd2) begin
      miscompares++;
      $display("FAIL reset_fill: count=%0d want 2", count);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (count !== 2'd0 || out_valid !== '0 || outp !== '0) begin
      miscompares++;
      $display("FAIL reset_async: count=%0d out_valid=%b outp=%h want 0", count, out_valid, outp);
    end
    cyc();
    rst = 1'b0; sel = 2'd0;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 0001", in_ready);
    end
  endtask

  task automatic test_single();
    sel = 2'd2; inp = '0; inp[2] = 16'hBEEF; in_valid = 4'b0100; out_ready = 4'hF;
    cyc();
    in_valid = '0;
    vectors++;
    if (out_valid !== 4'b0100 || outp[2] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL single_out: out_valid=%b outp2=%h want 0100 beef", out_valid, outp[2]);
    end
    cyc();
    vectors++;
    if (count !== 2'd0) begin
      miscompares++;
      $display("FAIL single_drain: count=%0d want 0", count);
    end
  endtask

  task automatic test_sel_change();
    out_ready = '0;
    sel = 2'd1; inp = '0; inp[1] = 16'h0001; in_valid = 4'b0010;
    cyc();
    sel = 2'd3; inp[3] = 16'h0002; in_valid = 4'b1000;
    cyc();
    in_valid = '0;
    vectors++;
    if (count !== 2'd2 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL selchg_full: count=%0d in_ready=%b want 2 0000", count, in_ready);
    end
    vectors++;
    if (out_valid !== 4'b0010 || outp[1] !== 16'h0001) begin
      miscompares++;
      $display("FAIL selchg_head1: out_valid=%b outp1=%h want 0010 0001", out_valid, outp[1]);
    end
    out_ready = 4'hF;
    cyc();
    vectors++;
    if (out_valid !== 4'b1000 || outp[3] !== 16'h0002) begin
      miscompares++;
      $display("FAIL selchg_head3: out_valid=%b outp3=%h want 1000 0002", out_valid, outp[3]);
    end
    cyc();
    vectors++;
    if (count !== 2'd0) begin
      miscompares++;
      $display("FAIL selchg_drain: count=%0d want 0", count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = '0;
    sel = 2'd2; inp = '0; inp[2] = 16'h1111; in_valid = 4'b0100;
    cyc();
    sel = 2'd0; inp[0] = 16'h2222; in_valid = 4'b0001;
    cyc();
    inp[0] = 16'h3333;
    out_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++;
      if (out_valid !== 4'b0100 || outp[2] !== 16'h1111 || count !== 2'd2) begin
        miscompares++;
        $display("FAIL bp_hold%0d: out_valid=%b outp2=%h count=%0d want 0100 1111 2", i, out_valid, outp[2], count);
      end
    end
    in_valid = '0; out_ready = 4'hF;
    cyc();
    vectors++;
    if (out_valid !== 4'b0001 || outp[0] !== 16'h2222) begin
      miscompares++;
      $display("FAIL bp_drain: out_valid=%b outp0=%h want 0001 2222", out_valid, outp[0]);
    end
    cyc();
  endtask

  task automatic test_stream();
    int p0;
    p0 = pops;
    sel = 2'd0; out_ready = 4'b0001; inp = '0;
    for (int i = 0; i < 16; i++) begin
      inp[0] = 16'(i); in_valid = 4'b0001;
      cyc();
    end
    in_valid = '0;
    cyc();
    vectors++;
    if (pops - p0 != 16 || count !== 2'd0) begin
      miscompares++;
      $display("FAIL stream_tput: pops=%0d count=%0d want 16 0", pops - p0, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      sel = SW'($urandom_range(0, C-1));
      in_valid = C'($urandom);
      out_ready = C'($urandom);
      for (int c = 0; c < C; c++) inp[c] = W'($urandom);
      cyc();
    end
    in_valid = '0; out_ready = 4'hF;
    cyc(); cyc(); cyc();
    vectors++;
    if (count !== 2'd0) begin
      miscompares++;
      $display("FAIL random_drain: count=%0d want 0", count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sel_change();
    test_backpressure();
    test_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
